// File: rtl/param_pipe_cska.sv
// Pipelined carry-skip adder: one BLOCK-wide slice per stage, global stall on backpressure,
// optional OR-approximation of the low APPROX_BITS bits, and a saturating skip-path counter.
module param_pipe_cska #(
   parameter int WIDTH       = 16,
   parameter int BLOCK       = 4,
   parameter int APPROX_BITS = 4,
   parameter int STAGES      = WIDTH / BLOCK
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              cin,
   input  logic              approx_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  sum,
   output logic              cout,
   output logic [STAGES-1:0] stage_en,
   output logic [15:0]       skip_cnt
);

   // The last stage never forwards operands, so only STAGES-1 operand registers exist.
   localparam int OPS = (STAGES > 1) ? STAGES - 1 : 1;

   logic                           advance;
   logic [STAGES-1:0]              vld_q, c_q, skp_q;
   logic [STAGES-1:0][WIDTH-1:0]   sum_q;
   logic [OPS-1:0][WIDTH-1:0]      a_q, b_q;
   logic [OPS-1:0]                 apx_q;
   logic [15:0]                    cnt_q;

   logic [STAGES-1:0]              vin_w, cin_w, apx_w, skp_w;
   logic [STAGES-1:0][WIDTH-1:0]   a_w, b_w, sin_w;
   logic [STAGES-1:0][WIDTH+1:0]   stg_d;

   // Returns {skip_taken, block_carry_out, partial_sum} for block s.
   function automatic logic [WIDTH+1:0] blk_add(
      input logic [WIDTH-1:0] a_v,
      input logic [WIDTH-1:0] b_v,
      input logic [WIDTH-1:0] s_v,
      input int               s,
      input logic             c_in,
      input logic             apx
   );
      logic [WIDTH-1:0] res;
      logic             c, p, all_p, skip;
      int               i;
      res   = s_v;
      c     = c_in;
      all_p = 1'b1;
      for (int j = 0; j < BLOCK; j++) begin
         i     = s * BLOCK + j;
         p     = a_v[i] ^ b_v[i];
         all_p = all_p & p;
         if (apx && (i < APPROX_BITS)) begin
            res[i] = a_v[i] | b_v[i];
            c      = (i == APPROX_BITS - 1) ? (a_v[i] & b_v[i]) : 1'b0;
         end else begin
            res[i] = p ^ c;
            c      = (a_v[i] & b_v[i]) | (p & c);
         end
      end
      // Blocks touching approximated bits never use the skip mux.
      skip = all_p & (~apx | (s * BLOCK >= APPROX_BITS));
      return {skip, (skip ? c_in : c), res};
   endfunction

   assign advance   = out_ready | ~vld_q[STAGES-1];
   assign in_ready  = advance;
   assign out_valid = vld_q[STAGES-1];
   assign sum       = sum_q[STAGES-1];
   assign cout      = c_q[STAGES-1];
   assign skip_cnt  = cnt_q;
   assign stage_en  = {STAGES{rst_n & advance}} & vin_w;

   for (genvar s = 0; s < STAGES; s++) begin : g_stg
      if (s == 0) begin : g_first
         assign vin_w[s] = in_valid;
         assign a_w[s]   = a;
         assign b_w[s]   = b;
         assign sin_w[s] = '0;
         assign cin_w[s] = cin;
         assign apx_w[s] = approx_en;
         assign skp_w[s] = 1'b0;
      end else begin : g_rest
         assign vin_w[s] = vld_q[s-1];
         assign a_w[s]   = a_q[s-1];
         assign b_w[s]   = b_q[s-1];
         assign sin_w[s] = sum_q[s-1];
         assign cin_w[s] = c_q[s-1];
         assign apx_w[s] = apx_q[s-1];
         assign skp_w[s] = skp_q[s-1];
      end
      assign stg_d[s] = blk_add(a_w[s], b_w[s], sin_w[s], s, cin_w[s], apx_w[s]);
   end

   // Valid bits move on every advance so empty slots propagate; data only on stage_en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         c_q   <= '0;
         skp_q <= '0;
         sum_q <= '0;
         a_q   <= '0;
         b_q   <= '0;
         apx_q <= '0;
         cnt_q <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (advance) vld_q[s] <= vin_w[s];
            if (stage_en[s]) begin
               sum_q[s] <= stg_d[s][WIDTH-1:0];
               c_q[s]   <= stg_d[s][WIDTH];
               skp_q[s] <= skp_w[s] | stg_d[s][WIDTH+1];
            end
         end
         for (int s = 0; s < OPS; s++) begin
            if ((STAGES > 1) && stage_en[s]) begin
               a_q[s]   <= a_w[s];
               b_q[s]   <= b_w[s];
               apx_q[s] <= apx_w[s];
            end
         end
         if (out_valid && out_ready && skp_q[STAGES-1] && (cnt_q != 16'hFFFF))
            cnt_q <= cnt_q + 16'd1;
      end
   end

endmodule
